serial_frame_receiver: RTL and testbench

SERIAL_FRAME_RECEIVER -- requirements
Module: serial_frame_receiver

---
 rtl/serial_frame_pkg.sv | 29 ++
 rtl/frame_bit_counter.sv | 45 ++++
 rtl/serial_frame_receiver.sv | 166 ++++++++++++++++
 tb/tb_serial_frame_receiver.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_pkg.sv
// ============================================================================
// Module : serial_frame_pkg
// Brief  : Shared types and constants for the serial frame receiver.
//          PARITY_CHECK_EN adds the PARITY state to the FSM encoding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package serial_frame_pkg;

   localparam int DEF_FRAME_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1
`ifdef PARITY_CHECK_EN
      ,
      ST_PARITY = 2'd2
`endif
   } frame_state_t;

   // Even-parity error: set when the data bits plus the parity bit hold an odd number of ones.
   function automatic logic parity_error(input logic [31:0] data, input logic parity_bit);
      return (^data) ^ parity_bit;
   endfunction

endpackage : serial_frame_pkg

`default_nettype wire

// File: rtl/frame_bit_counter.sv
// ============================================================================
// Module : frame_bit_counter
// Brief  : Data-bit counter with clear, increment and a last-bit flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module frame_bit_counter
   import serial_frame_pkg::*;
#(
   parameter int WIDTH = DEF_FRAME_WIDTH
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic incr,
   output logic last_bit
);

   localparam int                 CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]      LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0]      FULL = CW'(WIDTH);

   logic [CW-1:0] count;
   logic [CW-1:0] base;

   // A clear in the same cycle as an increment counts that bit as bit 0.
   always_comb begin
      base     = clear ? '0 : count;
      last_bit = incr && (base == LAST);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= incr ? CW'(1) : '0;
      end else if (incr && (count != FULL)) begin
         count <= count + CW'(1);
      end
   end

endmodule : frame_bit_counter

`default_nettype wire

// File: rtl/serial_frame_receiver.sv
// ============================================================================
// Module : serial_frame_receiver
// Brief  : Assembles qualified serial bits into WIDTH-bit words with a
//          single-entry output hold and sticky overrun. PARITY_CHECK_EN adds an
//          even-parity bit after the data bits and a parity_err output.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_frame_receiver
   import serial_frame_pkg::*;
#(
   parameter int WIDTH = DEF_FRAME_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             serial_in,
   input  logic             bit_valid,
   input  logic             frame_start,
   input  logic             lsb_first,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   input  logic             data_ready,
   output logic             busy,
   output logic             overrun
`ifdef PARITY_CHECK_EN
   ,
   output logic             parity_err
`endif
);

   frame_state_t     state;
   frame_state_t     state_next;
   logic [WIDTH-1:0] cap;
   logic [WIDTH-1:0] cap_next;
   logic             lsb_mode;
   logic             order_now;
   logic             accept;
   logic             last_bit;
   logic             complete;
   logic [WIDTH-1:0] word;
   logic             load;
`ifdef PARITY_CHECK_EN
   logic             word_perr;
`endif

   // A frame_start bit belongs to the new frame, so it uses the incoming order.
   assign order_now = frame_start ? lsb_first : lsb_mode;
   assign accept    = bit_valid && (frame_start || (state == ST_SHIFT));

   frame_bit_counter #(
      .WIDTH (WIDTH)
   ) u_bit_counter (
      .clk      (clk),
      .reset    (reset),
      .clear    (frame_start),
      .incr     (accept),
      .last_bit (last_bit)
   );

   always_comb begin
      cap_next = cap;
      if (accept) begin
         if (order_now) begin
            cap_next = {serial_in, cap[WIDTH-1:1]};
         end else begin
            cap_next = {cap[WIDTH-2:0], serial_in};
         end
      end
   end

`ifdef PARITY_CHECK_EN
   always_comb begin
      complete  = (state == ST_PARITY) && bit_valid && !frame_start;
      word      = cap;
      word_perr = parity_error(32'(cap), serial_in);
   end
`else
   always_comb begin
      complete = accept && last_bit;
      word     = cap_next;
   end
`endif

   always_comb begin
      state_next = state;
      if (frame_start) begin
         state_next = ST_SHIFT;
      end else begin
         unique case (state)
            ST_IDLE: begin
               state_next = ST_IDLE;
            end
            ST_SHIFT: begin
               if (accept && last_bit) begin
`ifdef PARITY_CHECK_EN
                  state_next = ST_PARITY;
`else
                  state_next = ST_IDLE;
`endif
               end
            end
`ifdef PARITY_CHECK_EN
            ST_PARITY: begin
               if (bit_valid) begin
                  state_next = ST_IDLE;
               end
            end
`endif
            default: begin
               state_next = ST_IDLE;
            end
         endcase
      end
   end

   assign busy = (state != ST_IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         cap      <= '0;
         lsb_mode <= 1'b0;
      end else begin
         state <= state_next;
         cap   <= cap_next;
         if (frame_start) begin
            lsb_mode <= lsb_first;
         end
      end
   end

   // The hold register only takes a new word when it is empty or being drained this cycle.
   assign load = complete && (!data_valid || data_ready);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_out   <= '0;
         data_valid <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (load) begin
            data_out   <= word;
            data_valid <= 1'b1;
         end else if (data_valid && data_ready) begin
            data_valid <= 1'b0;
         end
         if (complete && !load) begin
            overrun <= 1'b1;
         end
      end
   end

`ifdef PARITY_CHECK_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         parity_err <= 1'b0;
      end else if (load) begin
         parity_err <= word_perr;
      end
   end
`endif

endmodule : serial_frame_receiver

`default_nettype wire

// File: tb/tb_serial_frame_receiver.sv
// ============================================================================
// Module : tb_serial_frame_receiver
// Brief  : Directed and random checks of serial_frame_receiver against a
//          queue-based frame model. PARITY_CHECK_EN enables the parity cases.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_frame_receiver;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         serial_in, bit_valid, frame_start, lsb_first, data_ready;
   logic [W-1:0] data_out;
   logic         data_valid, busy, overrun;
`ifdef PARITY_CHECK_EN
   logic         parity_err;
`endif

   int checks = 0;
   int errors = 0;

   serial_frame_receiver #(.WIDTH(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .serial_in   (serial_in),
      .bit_valid   (bit_valid),
      .frame_start (frame_start),
      .lsb_first   (lsb_first),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .data_ready  (data_ready),
      .busy        (busy),
      .overrun     (overrun)
`ifdef PARITY_CHECK_EN
      ,
      .parity_err  (parity_err)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: bits of the current frame held as a list, word built arithmetically.
   bit         m_in_frame;
   bit         m_parity_phase;
   bit         m_lsb;
   int         m_bits[$];
   int         m_out;
   bit         m_valid;
   bit         m_ovr;
   bit         m_perr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int assemble();
      int w = 0;
      for (int i = 0; i < W; i++) begin
         if (m_lsb) w += m_bits[i] * (1 << i);
         else       w += m_bits[i] * (1 << (W - 1 - i));
      end
      return w;
   endfunction

   task automatic model_reset();
      m_in_frame = 0; m_parity_phase = 0; m_lsb = 0;
      m_bits.delete();
      m_out = 0; m_valid = 0; m_ovr = 0; m_perr = 0;
   endtask

   task automatic model_step(input bit fs, input bit bv, input bit si, input bit lsb, input bit rdy);
      bit done = 0;
      int word = 0;
      bit perr = 0;
      if (fs) begin
         m_bits.delete();
         m_lsb = lsb; m_in_frame = 1; m_parity_phase = 0;
         if (bv) m_bits.push_back(int'(si));
      end else if (m_in_frame && bv) begin
         if (m_parity_phase) begin
            int ones = int'(si);
            foreach (m_bits[i]) ones += m_bits[i];
            word = assemble(); perr = (ones % 2) == 1;
            done = 1; m_in_frame = 0; m_parity_phase = 0;
         end else begin
            m_bits.push_back(int'(si));
            if (m_bits.size() == W) begin
`ifdef PARITY_CHECK_EN
               m_parity_phase = 1;
`else
               word = assemble(); done = 1; m_in_frame = 0;
`endif
            end
         end
      end
      if (done) begin
         if (!m_valid || rdy) begin
            m_out = word; m_valid = 1; m_perr = perr;
         end else begin
            m_ovr = 1;
         end
      end else if (m_valid && rdy) begin
         m_valid = 0;
      end
   endtask

   task automatic compare_all();
      chk("data_out", 32'(data_out), 32'(m_out));
      chk("data_valid", 32'(data_valid), 32'(m_valid));
      chk("busy", 32'(busy), 32'(m_in_frame));
      chk("overrun", 32'(overrun), 32'(m_ovr));
`ifdef PARITY_CHECK_EN
      if (m_valid) chk("parity_err", 32'(parity_err), 32'(m_perr));
`endif
   endtask

   task automatic cyc(input bit fs, input bit bv, input bit si, input bit lsb, input bit rdy);
      frame_start = fs; bit_valid = bv; serial_in = si; lsb_first = lsb; data_ready = rdy;
      @(posedge clk);
      model_step(fs, bv, si, lsb, rdy);
      #1;
      compare_all();
   endtask

   task automatic send_frame(input logic [W-1:0] word, input bit lsb, input bit rdy, input bit pbit);
      logic [W-1:0] w = word;
      for (int i = 0; i < W; i++) begin
         cyc(i == 0, 1'b1, lsb ? w[i] : w[W-1-i], lsb, rdy);
      end
`ifdef PARITY_CHECK_EN
      cyc(1'b0, 1'b1, pbit, lsb, rdy);
`else
      if (pbit) begin end
`endif
   endtask

   task automatic pulse_reset();
      frame_start = 0; bit_valid = 0;
      #3 reset = 1'b1;
      model_reset();
      #1;
      compare_all();
      chk("rst_data_out", 32'(data_out), 32'h0);
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; serial_in = 0; bit_valid = 0; frame_start = 0; lsb_first = 0; data_ready = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      reset = 1'b0;

      // MSB-first 1,1,0,0,0,0,0,0 -> C0, valid for one cycle
      send_frame(8'hC0, 1'b0, 1'b1, 1'b0);
      chk("msb_c0", 32'(data_out), 32'hC0);
      chk("msb_c0_valid", 32'(data_valid), 32'h1);
      cyc(0, 0, 0, 0, 1);
      chk("msb_c0_drop", 32'(data_valid), 32'h0);

      // Same bit sequence LSB-first -> 03
      send_frame(8'h03, 1'b1, 1'b1, 1'b0);
      chk("lsb_03", 32'(data_out), 32'h03);
      cyc(0, 0, 0, 0, 1);

      // Overrun: A5 held, 3C dropped
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
      chk("ovr_hold", 32'(data_out), 32'hA5);
      chk("ovr_flag", 32'(overrun), 32'h1);
      cyc(0, 0, 0, 0, 1);
      chk("ovr_drop_valid", 32'(data_valid), 32'h0);
      chk("ovr_sticky", 32'(overrun), 32'h1);

      // Restarted frame discards the partial one
      pulse_reset();
      cyc(1, 1, 1, 0, 1);
      cyc(0, 1, 0, 0, 1);
      cyc(0, 1, 1, 0, 1);
      send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
      chk("restart_5a", 32'(data_out), 32'h5A);
      chk("restart_ovr", 32'(overrun), 32'h0);
      cyc(0, 0, 0, 0, 1);

      // Reset mid-frame, then bits without frame_start are ignored
      for (int i = 0; i < 5; i++) cyc(i == 0, 1, 1, 0, 1);
      pulse_reset();
      for (int i = 0; i < 3; i++) begin
         cyc(0, 1, 1, 0, 1);
         chk("post_rst_valid", 32'(data_valid), 32'h0);
         chk("post_rst_busy", 32'(busy), 32'h0);
      end

`ifdef PARITY_CHECK_EN
      send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
      chk("perr_set", 32'(parity_err), 32'h1);
      cyc(0, 0, 0, 0, 1);
      send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
      chk("perr_clr", 32'(parity_err), 32'h0);
      cyc(0, 0, 0, 0, 1);
`endif

      // Randomized traffic
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(499, 0) == 0) begin
            pulse_reset();
         end else begin
            cyc($urandom_range(11, 0) == 0, $urandom_range(3, 0) != 0,
                1'($urandom), 1'($urandom), 1'($urandom));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_serial_frame_receiver

`default_nettype wire
